// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two valid/ready requesters.
// Latency: grant in T, execute in T+1, tagged result held from T+2 until accepted.
// Backpressure: rsp_ready low holds the result and blocks all new grants.
module alu_share_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         rsp_carry,
    output logic         rsp_err,
    input  logic         rsp_ready,
    output logic         busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;

    logic [1:0]   r_state;
    logic         r_last;
    logic [2:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_id;

    logic         r_rsp_valid;
    logic         r_rsp_id;
    logic [W-1:0] r_rsp_data;
    logic         r_rsp_carry;
    logic         r_rsp_err;

    logic         w_idle;
    logic         w_grant;
    logic         w_grant_id;
    logic [W:0]   w_sum;
    logic [W:0]   w_sub;
    logic [W-1:0] w_data;
    logic         w_carry;
    logic         w_err;

    // Tie goes to whoever was not granted last; a lone request wins outright.
    // Ready depends only on state, valids and pointer, never on payload.
    assign w_idle     = (r_state == S_IDLE);
    assign w_grant    = w_idle & (req0_valid | req1_valid);
    assign w_grant_id = (req0_valid & req1_valid) ? ~r_last : req1_valid;

    // Readies are masked while reset is held so every output reads 0 during reset.
    assign req0_ready = rst_n & w_grant & ~w_grant_id;
    assign req1_ready = rst_n & w_grant &  w_grant_id;
    assign busy       = ~w_idle;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_err    = r_rsp_err;

    // Subtract as a + ~b + 1 so bit W is the no-borrow flag.
    assign w_sum = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub = {1'b0, r_a} + {1'b0, ~r_b} + {{W{1'b0}}, 1'b1};

    // ALU on the captured operands; opcodes 6 and 7 flag an error with zero data.
    always_comb begin
        w_data  = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (r_op)
            OP_SUM: begin
                w_data  = w_sum[W-1:0];
                w_carry = w_sum[W];
            end
            OP_SUB: begin
                w_data  = w_sub[W-1:0];
                w_carry = w_sub[W];
            end
            OP_AND: w_data = r_a & r_b;
            OP_OR:  w_data = r_a | r_b;
            OP_SHL: begin
                w_data  = {r_a[W-2:0], 1'b0};
                w_carry = r_a[W-1];
            end
            OP_SHR: begin
                w_data  = {1'b0, r_a[W-1:1]};
                w_carry = r_a[0];
            end
            default: w_err = 1'b1;
        endcase
    end

    // Sequencer: grant and capture in IDLE, one execute cycle, hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_id    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_op    <= w_grant_id ? req1_op : req0_op;
                        r_a     <= w_grant_id ? req1_a  : req0_a;
                        r_b     <= w_grant_id ? req1_b  : req0_b;
                        r_id    <= w_grant_id;
                        r_last  <= w_grant_id;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: r_state <= S_RESP;
                S_RESP: begin
                    if (r_rsp_valid && rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Result register: loaded at the end of EXEC, valid dropped on the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= w_data;
            r_rsp_carry <= w_carry;
            r_rsp_err   <= w_err;
        end else if (r_state == S_RESP && r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed cases with literal results plus random traffic.
// A transaction-level model (age since grant, arithmetic ALU) is compared every cycle.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic [2:0] req0_op = '0;
    logic [7:0] req0_a = '0;
    logic [7:0] req0_b = '0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [2:0] req1_op = '0;
    logic [7:0] req1_a = '0;
    logic [7:0] req1_b = '0;
    logic       req1_ready;
    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_err;
    logic       rsp_ready = 1'b0;
    logic       busy;

    int n_chk = 0;
    int n_fail = 0;

    alu_share_arbiter #(.W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rdy0"}, req0_ready, 0);
        chk({name, "_rdy1"}, req1_ready, 0);
        chk({name, "_vld"},  rsp_valid, 0);
        chk({name, "_id"},   rsp_id, 0);
        chk({name, "_data"}, rsp_data, 0);
        chk({name, "_cy"},   rsp_carry, 0);
        chk({name, "_err"},  rsp_err, 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    // Arithmetic reference for the six operations, modulo 256.
    function automatic void model_alu(input int op, input int a, input int b,
                                      output int d, output int c, output int e);
        d = 0; c = 0; e = 0;
        case (op)
            0: begin d = (a + b) % 256; c = ((a + b) > 255) ? 1 : 0; end
            1: begin d = (a - b + 256) % 256; c = (a >= b) ? 1 : 0; end
            2: d = a & b;
            3: d = a | b;
            4: begin d = (a * 2) % 256; c = a / 128; end
            5: begin d = a / 2; c = a % 2; end
            default: e = 1;
        endcase
    endfunction

    // Model: m_age is cycles since the grant (-1 when free); result visible from age 2.
    int m_age = -1;
    int m_last = 1;
    int m_id = 0, m_data = 0, m_carry = 0, m_err = 0;
    int g0, g1;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_age  = -1;
            m_last = 1;
        end else begin
            g0 = (m_age < 0 && req0_valid && (!req1_valid || m_last == 1)) ? 1 : 0;
            g1 = (m_age < 0 && req1_valid && (!req0_valid || m_last == 0)) ? 1 : 0;
            chk("mdl_rdy0", req0_ready, g0);
            chk("mdl_rdy1", req1_ready, g1);
            chk("mdl_busy", busy, (m_age >= 1) ? 1 : 0);
            chk("mdl_vld", rsp_valid, (m_age >= 2) ? 1 : 0);
            if (m_age >= 2) begin
                chk("mdl_id", rsp_id, m_id);
                chk("mdl_data", rsp_data, m_data);
                chk("mdl_carry", rsp_carry, m_carry);
                chk("mdl_err", rsp_err, m_err);
            end
            if (m_age < 0) begin
                if (g0 == 1) begin
                    m_id = 0;
                    model_alu(int'(req0_op), int'(req0_a), int'(req0_b), m_data, m_carry, m_err);
                end else if (g1 == 1) begin
                    m_id = 1;
                    model_alu(int'(req1_op), int'(req1_a), int'(req1_b), m_data, m_carry, m_err);
                end
                if (g0 == 1 || g1 == 1) begin
                    m_last = m_id;
                    m_age  = 1;
                end
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (rsp_ready) begin
                m_age = -1;
            end
        end
    end

    int gl[4];
    int n_grant, n_res;
    logic a0, a1;

    initial begin
        // Reset defaults
        @(posedge clk);
        chk_all_zero("in_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all_zero("reset_dflt");
        end

        // Tie: both valid continuously, grants alternate starting with req0
        tick();
        req0_valid = 1; req0_op = 3'd1; req0_a = 8'd5;    req0_b = 8'd7;
        req1_valid = 1; req1_op = 3'd4; req1_a = 8'h81;   req1_b = 8'h5A;
        rsp_ready = 1;
        n_grant = 0; n_res = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                if (n_grant < 4) gl[n_grant] = req1_ready ? 1 : 0;
                n_grant++;
            end
            if (rsp_valid) begin
                n_res++;
                if (rsp_id == 1'b0) begin
                    chk("tie_r0_data", rsp_data, 8'hFE);
                    chk("tie_r0_cy", rsp_carry, 0);
                end else begin
                    chk("tie_r1_data", rsp_data, 8'h02);
                    chk("tie_r1_cy", rsp_carry, 1);
                end
            end
        end
        tick();
        req0_valid = 0; req1_valid = 0;
        chk("tie_n_grant", n_grant, 4);
        chk("tie_n_res", n_res, 4);
        for (int i = 0; i < 4; i++) chk("tie_grant_seq", gl[i], i % 2);
        repeat (2) tick();

        // Single SUM: 200 + 100 = 300 -> 44 with carry
        req0_valid = 1; req0_op = 3'd0; req0_a = 8'd200; req0_b = 8'd100; rsp_ready = 1;
        @(negedge clk);
        chk("sum_rdy0", req0_ready, 1);
        chk("sum_rdy1", req1_ready, 0);
        tick();
        req0_valid = 0; req0_a = 8'd0;
        @(negedge clk);
        chk("sum_busy_exec", busy, 1);
        chk("sum_vld_exec", rsp_valid, 0);
        @(negedge clk);
        chk("sum_vld", rsp_valid, 1);
        chk("sum_id", rsp_id, 0);
        chk("sum_data", rsp_data, 44);
        chk("sum_cy", rsp_carry, 1);
        chk("sum_err", rsp_err, 0);
        tick();

        // Backpressure: req1 SHR 0x03 held for 10 cycles, req0 waits
        rsp_ready = 0; req1_valid = 1; req1_op = 3'd5; req1_a = 8'h03; req1_b = 8'hC3;
        @(negedge clk);
        chk("bp_rdy1", req1_ready, 1);
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_op = 3'd2; req0_a = 8'hF0; req0_b = 8'h3C;
        @(negedge clk);
        chk("bp_rdy0_exec", req0_ready, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_vld", rsp_valid, 1);
            chk("bp_id", rsp_id, 1);
            chk("bp_data", rsp_data, 8'h01);
            chk("bp_cy", rsp_carry, 1);
            chk("bp_rdy0", req0_ready, 0);
        end
        tick();
        rsp_ready = 1;
        @(negedge clk);
        chk("bp_hs_vld", rsp_valid, 1);
        chk("bp_hs_rdy0", req0_ready, 0);
        @(negedge clk);
        chk("bp_after_vld", rsp_valid, 0);
        chk("bp_after_rdy0", req0_ready, 1);
        tick();
        req0_valid = 0;
        repeat (3) tick();

        // Illegal opcode
        req0_valid = 1; req0_op = 3'd7; req0_a = 8'hFF; req0_b = 8'hFF;
        @(negedge clk);
        chk("ill_rdy0", req0_ready, 1);
        tick();
        req0_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("ill_vld", rsp_valid, 1);
        chk("ill_data", rsp_data, 0);
        chk("ill_cy", rsp_carry, 0);
        chk("ill_err", rsp_err, 1);
        tick();

        // Reset while a result is held
        rsp_ready = 0; req0_valid = 1; req0_op = 3'd3; req0_a = 8'h12; req0_b = 8'h21;
        @(negedge clk);
        tick();
        req0_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_vld", rsp_valid, 1);
        chk("rst_pre_data", rsp_data, 8'h33);
        tick();
        req0_valid = 1; req1_valid = 1;
        req1_op = 3'd0; req1_a = 8'd1; req1_b = 8'd2;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tie_rdy0", req0_ready, 1);
        chk("rst_tie_rdy1", req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        repeat (3) tick();

        // Random traffic, requesters hold payload until accepted
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            a0 = req0_ready;
            a1 = req1_ready;
            @(posedge clk);
            #1;
            if (!req0_valid || a0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_op    = 3'($urandom_range(0, 7));
                req0_a     = 8'($urandom);
                req0_b     = 8'($urandom);
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_op    = 3'($urandom_range(0, 7));
                req1_a     = 8'($urandom);
                req1_b     = 8'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        a0 = req0_ready;
        a1 = req1_ready;
        tick();
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        repeat (5) tick();
        @(negedge clk);
        chk("final_idle_busy", busy, 0);
        chk("final_idle_vld", rsp_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one 8-bit ALU (sum, subtract, AND, OR, shift-left, shift-right) between two requesters. Each requester submits an operation over a valid/ready handshake. The block grants one requester, executes the operation in a registered execute stage and holds a tagged result until the consumer accepts it. It sits between the operand/operation sources (switch/button front-end, or a second control agent) and the display/result path.

## Interface
- `W`, default 8: operand and result width; only 8 is supported.

Ports:
- `clk` in 1: system clock; all state is updated on the rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_op` in 3: requester 0 opcode.
- `req0_a` in 8: requester 0 operand A.
- `req0_b` in 8: requester 0 operand B.
- `req0_ready` out 1: requester 0 operation accepted this cycle.
- `req1_valid`, `req1_op`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `rsp_valid` out 1: a result is held.
- `rsp_id` out 1: index of the requester that issued the held result.
- `rsp_data` out 8: result.
- `rsp_carry` out 1: carry, no-borrow, or shifted-out bit.
- `rsp_err` out 1: the opcode was illegal.
- `rsp_ready` in 1: consumer accepts the result.
- `busy` out 1: the FSM is not in IDLE.

## Operation
- The FSM has three states: IDLE, EXEC, RESP. Reset enters IDLE.
- **IDLE**
  - If exactly one `reqN_valid` is high, grant that requester.
  - If both are high, grant the requester that was not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - The granted requester's `reqN_ready` is driven combinationally high in the same cycle. The other requester's ready stays low.
  - On the grant edge: capture op, a, b and id into registers, update the last-grant pointer, and move to EXEC.
  - With no valid request, stay in IDLE.
- **EXEC**
  - Compute from the captured registers.
  - Register `rsp_data`, `rsp_carry`, `rsp_err` and `rsp_id`, set `rsp_valid`, and move to RESP.
- **RESP**
  - Hold all `rsp_*` outputs stable.
  - On `rsp_valid & rsp_ready`: clear `rsp_valid` and move to IDLE.
  - No request is accepted while the FSM is in RESP.
- **Opcodes** (all arithmetic is modulo 256):
  - 0 SUM: data = a+b; carry = bit 8 of a+b.
  - 1 SUB: data = a−b, computed as a+~b+1; carry = 1 when a ≥ b (no borrow).
  - 2 AND: data = a&b; carry = 0.
  - 3 OR: data = a|b; carry = 0.
  - 4 SHL: data = {a[6:0],0}; carry = a[7]. b is ignored.
  - 5 SHR: data = {0,a[7:1]}; carry = a[0]. b is ignored.
  - 6, 7: data = 0, carry = 0, err = 1.
  - `rsp_err` is 0 for opcodes 0–5.
- **Ready and valid behaviour**
  - `reqN_ready` is low in EXEC and RESP.
  - Requesters hold valid and payload until ready. The block does not check this.
  - Payload is sampled only on the grant edge. Changes after that edge have no effect.
- **Reset mid-operation**
  - An in-flight or held result is discarded.
  - All outputs go to 0 immediately.
  - After release, the FSM is in IDLE and the pointer is 1.

## Timing
- Reset values: `req0_ready`, `req1_ready` = 0 (IDLE with no valid); `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_carry`, `rsp_err`, `busy` = 0.
- Grant in cycle T (ready high in T) → EXEC in cycle T+1 → `rsp_valid` high from cycle T+2.
- If `rsp_ready` is already high in T+2, the result handshakes that cycle and the FSM is in IDLE in T+3. The next grant can occur in T+3.
- Maximum throughput is one operation per 3 cycles.
- `busy` is high in EXEC and RESP, i.e. from T+1 through the handshake cycle.
- `rsp_ready` held low stalls indefinitely in RESP with stable outputs. Pending requesters wait with ready low.
- `reqN_ready` is a combinational function of the state, both valids and the pointer. There is no path from the payload inputs to ready.

## Test plan
- **Reset defaults:** after reset with both valids at 0, all outputs are 0 and the FSM stays in IDLE.
- **Single SUM:** req0 op=0, a=200, b=100, `rsp_ready`=1.
  - `req0_ready` is high in cycle T.
  - In T+2: `rsp_valid`=1, `rsp_id`=0, `rsp_data`=44, `rsp_carry`=1, `rsp_err`=0.
- **Tie arbitration:** both requesters valid continuously. req0 is op=1 a=5 b=7; req1 is op=4 a=0x81.
  - Grants alternate 0,1,0,…
  - req0 results: data=0xFE, carry=0.
  - req1 results: data=0x02, carry=1.
- **Backpressure:** req1 op=5 a=0x03, `rsp_ready`=0 for 10 cycles.
  - `rsp_valid` stays 1 with data=0x01, carry=1 held stable.
  - A req0 request stays unaccepted until one cycle after the handshake.
- **Illegal opcode:** req0 op=7, a=0xFF, b=0xFF → data=0, carry=0, err=1.
- **Reset in RESP:** assert `rst_n`=0 while `rsp_valid`=1.
  - All outputs drop to 0 asynchronously.
  - After release, a both-valid tie grants req0.
